// File: rtl/rv_decode_pkg.sv
// Shared decode constants: operation codes, base opcodes, immediate formats
// and the immediate extraction helper.
package rv_decode_pkg;

  localparam int OP_NONE   = 0;
  localparam int OP_ADD    = 1;
  localparam int OP_SUB    = 2;
  localparam int OP_SLL    = 3;
  localparam int OP_SLT    = 4;
  localparam int OP_SLTU   = 5;
  localparam int OP_XOR    = 6;
  localparam int OP_SRL    = 7;
  localparam int OP_SRA    = 8;
  localparam int OP_OR     = 9;
  localparam int OP_AND    = 10;
  localparam int OP_ADDI   = 11;
  localparam int OP_SLTI   = 12;
  localparam int OP_SLTIU  = 13;
  localparam int OP_XORI   = 14;
  localparam int OP_ORI    = 15;
  localparam int OP_ANDI   = 16;
  localparam int OP_SLLI   = 17;
  localparam int OP_SRLI   = 18;
  localparam int OP_SRAI   = 19;
  localparam int OP_LUI    = 20;
  localparam int OP_AUIPC  = 21;
  localparam int OP_JAL    = 22;
  localparam int OP_JALR   = 23;
  localparam int OP_BEQ    = 24;
  localparam int OP_BNE    = 25;
  localparam int OP_BLT    = 26;
  localparam int OP_BGE    = 27;
  localparam int OP_BLTU   = 28;
  localparam int OP_BGEU   = 29;
  localparam int OP_LB     = 30;
  localparam int OP_LH     = 31;
  localparam int OP_LW     = 32;
  localparam int OP_LBU    = 33;
  localparam int OP_LHU    = 34;
  localparam int OP_SB     = 35;
  localparam int OP_SH     = 36;
  localparam int OP_SW     = 37;
  // M-extension codes follow funct3 order so they can be offset from OP_MUL
  localparam int OP_MUL    = 38;
  localparam int OP_MULH   = 39;
  localparam int OP_MULHSU = 40;
  localparam int OP_MULHU  = 41;
  localparam int OP_DIV    = 42;
  localparam int OP_DIVU   = 43;
  localparam int OP_REM    = 44;
  localparam int OP_REMU   = 45;
  localparam int OP_FENCE  = 46;
  localparam int OP_ECALL  = 47;
  localparam int OP_EBREAK = 48;
  localparam int OP_LAST   = OP_EBREAK;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  function automatic logic [31:0] imm_of(input fmt_e f, input logic [31:0] i);
    case (f)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'h000};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_core.sv
// Purely combinational RV32I/M instruction decoder: operation code, immediate,
// operand-use flags, writeback enable and illegal-encoding flag.
module rv_decode_core
  import rv_decode_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter bit EN_M_EXT = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [OP_W-1:0] op,
  output logic [31:0]     imm,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            rd_we,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  int         code;
  fmt_e       fmt;
  logic       wr, u1, u2, ill;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    code = OP_NONE;
    fmt  = FMT_NONE;
    wr   = 1'b0;
    u1   = 1'b0;
    u2   = 1'b0;
    ill  = 1'b0;
    case (opc)
      OPC_OP: begin
        fmt = FMT_R; wr = 1'b1; u1 = 1'b1; u2 = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  code = OP_ADD;
            3'b001:  code = OP_SLL;
            3'b010:  code = OP_SLT;
            3'b011:  code = OP_SLTU;
            3'b100:  code = OP_XOR;
            3'b101:  code = OP_SRL;
            3'b110:  code = OP_OR;
            default: code = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) code = OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) code = OP_SRA;
        else if (f7 == 7'b0000001 && EN_M_EXT) code = OP_MUL + int'(f3);
        else ill = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt = FMT_I; wr = 1'b1; u1 = 1'b1;
        case (f3)
          3'b000:  code = OP_ADDI;
          3'b010:  code = OP_SLTI;
          3'b011:  code = OP_SLTIU;
          3'b100:  code = OP_XORI;
          3'b110:  code = OP_ORI;
          3'b111:  code = OP_ANDI;
          3'b001:  if (f7 == 7'b0000000) code = OP_SLLI; else ill = 1'b1;
          default: begin
            if (f7 == 7'b0000000) code = OP_SRLI;
            else if (f7 == 7'b0100000) code = OP_SRAI;
            else ill = 1'b1;
          end
        endcase
      end
      OPC_LUI:   begin fmt = FMT_U; wr = 1'b1; code = OP_LUI;   end
      OPC_AUIPC: begin fmt = FMT_U; wr = 1'b1; code = OP_AUIPC; end
      OPC_JAL:   begin fmt = FMT_J; wr = 1'b1; code = OP_JAL;   end
      OPC_JALR: begin
        fmt = FMT_I; wr = 1'b1; u1 = 1'b1;
        if (f3 == 3'b000) code = OP_JALR; else ill = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = FMT_B; u1 = 1'b1; u2 = 1'b1;
        case (f3)
          3'b000:  code = OP_BEQ;
          3'b001:  code = OP_BNE;
          3'b100:  code = OP_BLT;
          3'b101:  code = OP_BGE;
          3'b110:  code = OP_BLTU;
          3'b111:  code = OP_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I; wr = 1'b1; u1 = 1'b1;
        case (f3)
          3'b000:  code = OP_LB;
          3'b001:  code = OP_LH;
          3'b010:  code = OP_LW;
          3'b100:  code = OP_LBU;
          3'b101:  code = OP_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S; u1 = 1'b1; u2 = 1'b1;
        case (f3)
          3'b000:  code = OP_SB;
          3'b001:  code = OP_SH;
          3'b010:  code = OP_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        fmt = FMT_I;
        if (f3 == 3'b000) code = OP_FENCE; else ill = 1'b1;
      end
      OPC_SYSTEM: begin
        fmt = FMT_I;
        if (instr[31:7] == 25'h0000000) code = OP_ECALL;
        else if (instr[31:7] == 25'h0002000) code = OP_EBREAK;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  // Illegal encodings report a clean, inert bundle apart from the raw register fields
  assign illegal  = ill;
  assign op       = ill ? '0 : OP_W'(code);
  assign imm      = ill ? 32'h0 : imm_of(fmt, instr);
  assign rs1_used = u1 & ~ill;
  assign rs2_used = u2 & ~ill;
  assign rd_we    = wr & ~ill & (instr[11:7] != 5'd0);

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage between fetch and execute: 1- or 2-register valid/ready pipeline
// around rv_decode_core, with flush and per-instruction PC carry.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter bit EN_M_EXT    = 1'b0,
  parameter int PC_W        = 32,
  parameter int OP_W        = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [OP_W-1:0] out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);

  if ((1 << OP_W) <= OP_LAST) begin : g_opw_bad
    $error("OP_W too narrow for the operation codes");
  end

  logic            dec_vld;
  logic [31:0]     dec_instr;
  logic [PC_W-1:0] dec_pc;
  logic [OP_W-1:0] core_op;
  logic [31:0]     core_imm;
  logic            core_u1, core_u2, core_we, core_ill;

  logic            vld_p1, ready_p1;
  logic [PC_W-1:0] pc_p1;
  logic [OP_W-1:0] op_p1;
  logic [4:0]      rs1_p1, rs2_p1, rd_p1;
  logic [31:0]     imm_p1;
  logic            u1_p1, u2_p1, we_p1, ill_p1;

  assign ready_p1 = !vld_p1 || out_ready;

  if (PIPE_STAGES == 2) begin : g_two
    logic            vld_p0, ready_p0;
    logic [31:0]     instr_p0;
    logic [PC_W-1:0] pc_p0;

    assign ready_p0 = !vld_p0 || ready_p1;

    // Stage A boundary: raw instruction and PC
    always_ff @(posedge clk) begin
      if (reset)         vld_p0 <= 1'b0;
      else if (flush)    vld_p0 <= 1'b0;
      else if (ready_p0) vld_p0 <= in_valid;
      if (!flush && ready_p0 && in_valid) begin
        instr_p0 <= in_instr;
        pc_p0    <= in_pc;
      end
    end

    assign dec_vld   = vld_p0;
    assign dec_instr = instr_p0;
    assign dec_pc    = pc_p0;
    assign in_ready  = ready_p0;
  end else if (PIPE_STAGES == 1) begin : g_one
    assign dec_vld   = in_valid;
    assign dec_instr = in_instr;
    assign dec_pc    = in_pc;
    assign in_ready  = ready_p1;
  end else begin : g_bad
    $error("PIPE_STAGES must be 1 or 2");
  end

  rv_decode_core #(.OP_W(OP_W), .EN_M_EXT(EN_M_EXT)) u_core (
    .instr    (dec_instr),
    .op       (core_op),
    .imm      (core_imm),
    .rs1_used (core_u1),
    .rs2_used (core_u2),
    .rd_we    (core_we),
    .illegal  (core_ill)
  );

  // Stage B boundary: decoded bundle, also cleared by reset so outputs read 0
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
      op_p1  <= OP_W'(OP_NONE);
      rs1_p1 <= '0;
      rs2_p1 <= '0;
      rd_p1  <= '0;
      imm_p1 <= '0;
      u1_p1  <= 1'b0;
      u2_p1  <= 1'b0;
      we_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else begin
      if (flush)         vld_p1 <= 1'b0;
      else if (ready_p1) vld_p1 <= dec_vld;
      if (!flush && ready_p1 && dec_vld) begin
        pc_p1  <= dec_pc;
        op_p1  <= core_op;
        rs1_p1 <= dec_instr[19:15];
        rs2_p1 <= dec_instr[24:20];
        rd_p1  <= dec_instr[11:7];
        imm_p1 <= core_imm;
        u1_p1  <= core_u1;
        u2_p1  <= core_u2;
        we_p1  <= core_we;
        ill_p1 <= core_ill;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_pc       = pc_p1;
  assign out_op       = op_p1;
  assign out_rs1      = rs1_p1;
  assign out_rs2      = rs2_p1;
  assign out_rd       = rd_p1;
  assign out_imm      = imm_p1;
  assign out_rs1_used = u1_p1;
  assign out_rs2_used = u2_p1;
  assign out_rd_we    = we_p1;
  assign out_illegal  = ill_p1;

endmodule
